// File: rtl/huc_pkg.sv
// Shared types and constants for the HuC6280 bus initiator: FSM states,
// page decode boundaries and the chip-select bundle.
package huc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    LATCH  = 2'd3
  } bus_state_t;

  localparam logic [7:0]  PAGE_RAM_FIRST = 8'hF8;
  localparam logic [7:0]  PAGE_RAM_LAST  = 8'hFB;
  localparam logic [7:0]  PAGE_IO        = 8'hFF;
  localparam logic [7:0]  OPEN_BUS_DATA  = 8'hFF;
  localparam logic [12:0] VDCVCE_LIMIT   = 13'h800;

  // Active-high selects; all-zero means the page is open bus.
  typedef struct packed {
    logic rom;
    logic ram;
    logic io;
  } chip_sel_t;

  function automatic chip_sel_t decodePage(input logic [7:0] page);
    chip_sel_t sel;
    sel.rom = (page < PAGE_RAM_FIRST);
    sel.ram = (page >= PAGE_RAM_FIRST) && (page <= PAGE_RAM_LAST);
    sel.io  = (page == PAGE_IO);
    return sel;
  endfunction

endpackage

// File: rtl/huc_mmu.sv
// MPR mapping file with TMA read port, plus combinational logical-to-physical
// translation and chip-select decode of the translated page.
module huc_mmu
  import huc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_mprWe,
  input  logic [7:0]  i_mprSel,
  input  logic [7:0]  i_mprWdata,
  input  logic [2:0]  i_mprRdSel,
  output logic [7:0]  o_mprRdata,
  input  logic [15:0] i_logAddr,
  output logic [20:0] o_physAddr,
  output chip_sel_t   o_chipSel
);

  logic [7:0] r_mpr [0:7];
  logic [7:0] w_page;

  // TAM may hit several MPRs at once; translation reads the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_mpr[i] <= 8'h00;
    end else if (i_mprWe) begin
      for (int i = 0; i < 8; i++) begin
        if (i_mprSel[i]) r_mpr[i] <= i_mprWdata;
      end
    end
  end

  assign w_page     = r_mpr[i_logAddr[15:13]];
  assign o_physAddr = {w_page, i_logAddr[12:0]};
  assign o_chipSel  = decodePage(w_page);
  assign o_mprRdata = r_mpr[i_mprRdSel];

endmodule

// File: rtl/huc_bus_master.sv
// HuC6280 CPU-side bus initiator: accepts core byte requests, strobes the
// memory/IO responder and returns read data. Optional macro VDC_WAIT_STATE_EN
// inserts one WAIT cycle for VDC/VCE accesses on the IO page.
module huc_bus_master
  import huc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        mpr_we,
  input  logic [7:0]  mpr_sel,
  input  logic [7:0]  mpr_wdata,
  input  logic [2:0]  mpr_rd_sel,
  output logic [7:0]  mpr_rdata,
  output logic [20:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        bus_re,
  output logic        bus_we,
  output logic        ce_n,
  output logic        cer_n,
  output logic        ce7_n
);

  bus_state_t  r_state, w_nextState;
  logic [20:0] w_physAddr;
  chip_sel_t   w_chipSel, r_chipSel, w_txSel;
  logic        w_accept, w_txWrite, w_enActive, w_slow;
  logic        r_isWrite, r_busRe, r_busWe, r_ceN, r_cerN, r_ce7N, r_rspValid;
  logic [20:0] r_busAddr;
  logic [7:0]  r_busWdata, r_rspRdata;

  huc_mmu u_mmu (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mprWe    (mpr_we),
    .i_mprSel   (mpr_sel),
    .i_mprWdata (mpr_wdata),
    .i_mprRdSel (mpr_rd_sel),
    .o_mprRdata (mpr_rdata),
    .i_logAddr  (req_addr),
    .o_physAddr (w_physAddr),
    .o_chipSel  (w_chipSel)
  );

`ifdef VDC_WAIT_STATE_EN
  assign w_slow = (w_physAddr[20:13] == PAGE_IO) && (w_physAddr[12:0] < VDCVCE_LIMIT);
`else
  assign w_slow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_nextState = w_slow ? WAIT : ACCESS;
        end
      end
`ifdef VDC_WAIT_STATE_EN
      WAIT:    w_nextState = ACCESS;
`endif
      ACCESS:  w_nextState = r_isWrite ? IDLE : LATCH;
      LATCH:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Strobes and enables are registered from the next state so they line up with it.
  assign w_txWrite  = w_accept ? req_we : r_isWrite;
  assign w_txSel    = w_accept ? w_chipSel : r_chipSel;
  assign w_enActive = (w_nextState == WAIT) || (w_nextState == ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isWrite  <= 1'b0;
      r_chipSel  <= '0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_busRe    <= 1'b0;
      r_busWe    <= 1'b0;
      r_ceN      <= 1'b1;
      r_cerN     <= 1'b1;
      r_ce7N     <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspRdata <= 8'h00;
    end else begin
      if (w_accept) begin
        r_isWrite <= req_we;
        r_chipSel <= w_chipSel;
        r_busAddr <= w_physAddr;
        if (req_we) r_busWdata <= req_wdata;
      end
      r_busRe    <= (w_nextState == ACCESS) && !w_txWrite;
      r_busWe    <= (w_nextState == ACCESS) && w_txWrite;
      r_ceN      <= !(w_enActive && w_txSel.rom);
      r_cerN     <= !(w_enActive && w_txSel.ram);
      r_ce7N     <= !(w_enActive && w_txSel.io);
      r_rspValid <= (r_state == LATCH);
      if (r_state == LATCH) begin
        r_rspRdata <= (r_chipSel == '0) ? OPEN_BUS_DATA : bus_rdata;
      end
    end
  end

  assign ready     = (r_state == IDLE);
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign bus_addr  = r_busAddr;
  assign bus_wdata = r_busWdata;
  assign bus_re    = r_busRe;
  assign bus_we    = r_busWe;
  assign ce_n      = r_ceN;
  assign cer_n     = r_cerN;
  assign ce7_n     = r_ce7N;

endmodule

// File: tb/tb_huc_bus_master.sv
// Self-checking bench for huc_bus_master: directed scenarios followed by
// randomized traffic checked against a transaction-level bus/memory model.
module tb_huc_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        mpr_we = 1'b0;
  logic [7:0]  mpr_sel = 8'h0;
  logic [7:0]  mpr_wdata = 8'h0;
  logic [2:0]  mpr_rd_sel = 3'd0;
  logic [7:0]  mpr_rdata;
  logic [20:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h0;
  logic        bus_re, bus_we, ce_n, cer_n, ce7_n;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mprModel [8];
  logic [7:0] respMem  [int];
  logic [7:0] modelMem [int];
  logic [7:0] lastRead = 8'h00;
  bit         slowEn;

  huc_bus_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ready      (ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mpr_we     (mpr_we),
    .mpr_sel    (mpr_sel),
    .mpr_wdata  (mpr_wdata),
    .mpr_rd_sel (mpr_rd_sel),
    .mpr_rdata  (mpr_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_re     (bus_re),
    .bus_we     (bus_we),
    .ce_n       (ce_n),
    .cer_n      (cer_n),
    .ce7_n      (ce7_n)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memDefault(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h3C;
  endfunction

  // Synchronous responder: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (bus_re) bus_rdata <= respMem.exists(int'(bus_addr)) ? respMem[int'(bus_addr)] : memDefault(bus_addr);
    if (bus_we) respMem[int'(bus_addr)] = bus_wdata;
  end

  // Returns {ce_n, cer_n, ce7_n} as the memory map dictates for a page.
  function automatic logic [2:0] pageEnables(input logic [7:0] page);
    if (page <= 8'hF7)                     return 3'b011;
    else if (page >= 8'hF8 && page <= 8'hFB) return 3'b101;
    else if (page == 8'hFF)                return 3'b110;
    else                                   return 3'b111;
  endfunction

  function automatic logic [7:0] modelRead(input logic [20:0] a);
    return modelMem.exists(int'(a)) ? modelMem[int'(a)] : memDefault(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic writeMpr(input logic [7:0] sel, input logic [7:0] val);
    mpr_we = 1'b1; mpr_sel = sel; mpr_wdata = val;
    @(posedge clk);
    for (int i = 0; i < 8; i++) if (sel[i]) mprModel[i] = val;
    @(negedge clk);
    mpr_we = 1'b0;
  endtask

  // Issues one request (optionally with a same-edge MPR write) and checks the whole transaction.
  task automatic applyStimulus(input string tag, input logic we, input logic [15:0] addr,
                               input logic [7:0] wd, input logic mWe, input logic [7:0] mSel,
                               input logic [7:0] mVal);
    logic [7:0]  page;
    logic [20:0] expAddr;
    logic [2:0]  expEn;
    logic [7:0]  expData;
    bit          slow, done;
    int          strobes, enCycles, lat, expLat;
    page    = mprModel[addr[15:13]];
    expAddr = {page, addr[12:0]};
    expEn   = pageEnables(page);
    slow    = slowEn && (page == 8'hFF) && (addr[12:0] < 13'h800);
    expData = 8'h00;
    checkOutput({tag, "/ready_before"}, {31'd0, ready}, 32'd1);
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    mpr_we = mWe; mpr_sel = mSel; mpr_wdata = mVal;
    @(posedge clk);
    for (int i = 0; i < 8; i++) if (mWe && mSel[i]) mprModel[i] = mVal;
    if (we) modelMem[int'(expAddr)] = wd;
    else    expData = (expEn == 3'b111) ? 8'hFF : modelRead(expAddr);
    @(negedge clk);
    req = 1'b0; req_we = 1'b0; mpr_we = 1'b0;
    strobes = 0; enCycles = 0; lat = 0; done = 1'b0;
    expLat = (we ? 2 : 3) + (slow ? 1 : 0);
    while (!done && lat < 10) begin
      lat++;
      if (bus_re || bus_we) begin
        strobes++;
        checkOutput({tag, "/strobe_dir"}, {30'd0, bus_re, bus_we}, we ? 32'd1 : 32'd2);
        checkOutput({tag, "/bus_addr"}, {11'd0, bus_addr}, {11'd0, expAddr});
        if (we) checkOutput({tag, "/bus_wdata"}, {24'd0, bus_wdata}, {24'd0, wd});
      end
      if ({ce_n, cer_n, ce7_n} != 3'b111) begin
        enCycles++;
        checkOutput({tag, "/enables"}, {29'd0, ce_n, cer_n, ce7_n}, {29'd0, expEn});
      end
      if (we ? ready : rsp_valid) done = 1'b1;
      else @(negedge clk);
    end
    checkOutput({tag, "/latency"}, lat, expLat);
    checkOutput({tag, "/strobe_cycles"}, strobes, 1);
    checkOutput({tag, "/enable_cycles"}, enCycles, (expEn == 3'b111) ? 0 : (slow ? 2 : 1));
    if (!we) begin
      checkOutput({tag, "/rdata"}, {24'd0, rsp_rdata}, {24'd0, expData});
      checkOutput({tag, "/ready_with_rsp"}, {31'd0, ready}, 32'd1);
      lastRead = expData;
      @(negedge clk);
      checkOutput({tag, "/rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    end else begin
      checkOutput({tag, "/rdata_held"}, {24'd0, rsp_rdata}, {24'd0, lastRead});
      checkOutput({tag, "/no_rsp_on_write"}, {31'd0, rsp_valid}, 32'd0);
    end
    mpr_rd_sel = 3'($urandom_range(0, 7));
    #1;
    checkOutput({tag, "/mpr_rdata"}, {24'd0, mpr_rdata}, {24'd0, mprModel[mpr_rd_sel]});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "/bus_addr"}, {11'd0, bus_addr}, 32'd0);
    checkOutput({tag, "/bus_wdata"}, {24'd0, bus_wdata}, 32'd0);
    checkOutput({tag, "/strobes"}, {30'd0, bus_re, bus_we}, 32'd0);
    checkOutput({tag, "/enables"}, {29'd0, ce_n, cer_n, ce7_n}, 32'd7);
    checkOutput({tag, "/rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "/rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
    checkOutput({tag, "/ready"}, {31'd0, ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      mpr_rd_sel = 3'(i);
      #1;
      checkOutput({tag, "/mpr"}, {24'd0, mpr_rdata}, 32'd0);
    end
  endtask

  initial begin
    logic [7:0]  page;
    logic [2:0]  idx;
    logic [12:0] offs;
    bit          sawRsp;
`ifdef VDC_WAIT_STATE_EN
    slowEn = 1'b1;
`else
    slowEn = 1'b0;
`endif
    for (int i = 0; i < 8; i++) mprModel[i] = 8'h00;
    $display("[TB] starting, wait state model %0d", slowEn);
    repeat (2) @(negedge clk);
    checkResetState("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkResetState("after_reset");

    applyStimulus("rom_read", 1'b0, 16'hFFFE, 8'h00, 1'b0, 8'h00, 8'h00);
    writeMpr(8'h02, 8'hF8);
    applyStimulus("ram_write", 1'b1, 16'h2010, 8'h5A, 1'b0, 8'h00, 8'h00);
    applyStimulus("ram_read", 1'b0, 16'h2010, 8'h00, 1'b0, 8'h00, 8'h00);
    applyStimulus("same_edge", 1'b0, 16'h2000, 8'h00, 1'b1, 8'h02, 8'h00);
    writeMpr(8'h04, 8'hFD);
    applyStimulus("open_bus", 1'b0, 16'h4000, 8'h00, 1'b0, 8'h00, 8'h00);
    writeMpr(8'h08, 8'hFF);
    applyStimulus("vdc_read", 1'b0, 16'h6000, 8'h00, 1'b0, 8'h00, 8'h00);
    applyStimulus("io_fast", 1'b0, 16'h6900, 8'h00, 1'b0, 8'h00, 8'h00);
    applyStimulus("vdc_write", 1'b1, 16'h6002, 8'hA5, 1'b0, 8'h00, 8'h00);

    // Reset dropped while the read strobe is on the bus.
    req = 1'b1; req_we = 1'b0; req_addr = 16'h0123;
    @(negedge clk);
    req = 1'b0;
    checkOutput("mid_reset/re_before", {31'd0, bus_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset/re_drop", {31'd0, bus_re}, 32'd0);
    checkOutput("mid_reset/en_drop", {29'd0, ce_n, cer_n, ce7_n}, 32'd7);
    for (int i = 0; i < 8; i++) mprModel[i] = 8'h00;
    lastRead = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    sawRsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) sawRsp = 1'b1;
    end
    checkOutput("mid_reset/no_rsp", {31'd0, sawRsp}, 32'd0);
    checkResetState("mid_reset");

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) writeMpr(8'($urandom), 8'($urandom));
      idx = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: page = 8'($urandom_range(0, 8'hF7));
        1: page = 8'($urandom_range(8'hF8, 8'hFB));
        2: page = 8'($urandom_range(8'hFC, 8'hFE));
        default: page = 8'hFF;
      endcase
      writeMpr(8'(1 << idx), page);
      offs = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 15)) : 13'($urandom);
      applyStimulus("random", 1'($urandom_range(0, 1)), {idx, offs}, 8'($urandom),
                    1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
